// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encoding and default sizing.
package spi_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_XFER = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_e;

  localparam int DEF_DW  = 8;
  localparam int DEF_TMO = 255;

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping past NREQ-1.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] winOneHot_o,
  output logic [PW-1:0]   winIdx_o
);

  logic [NREQ-1:0] rot;
  int              sum;

  // Rotating the doubled request vector puts the request at ptr in bit 0,
  // so the lowest set bit of rot is the winner's distance from ptr.
  always_comb begin
    rot         = NREQ'({req_i, req_i} >> ptr_i);
    sum         = 0;
    winOneHot_o = '0;
    winIdx_o    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = int'(ptr_i) + k;
    end
    if (sum >= NREQ) sum = sum - NREQ;
    if (|req_i) begin
      winIdx_o              = PW'(sum);
      winOneHot_o[winIdx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters, with
// per-transfer timeout and a synchronised reset release.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DEF_DW,
  parameter int TMO  = DEF_TMO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_dat,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DW-1:0]        rsp_dat,
  output logic                 busy,
  output logic [DW-1:0]        spi_p_dat,
  output logic                 spi_tx_en,
  input  logic [DW-1:0]        spi_rcvd_dat,
  input  logic                 spi_tx_done
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TMO + 1);

  logic [1:0]      rstSync_q;
  logic            rstInt;
  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW-1:0]   rsp_q, rsp_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] winOneHot;
  logic [PW-1:0]   winIdx;
  logic [NREQ-1:0] ownerOneHot;

  // Assertion is immediate; release reaches the FSM only after two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstSync_q <= 2'b00;
    else      rstSync_q <= {rstSync_q[0], 1'b1};
  end
  assign rstInt = rstSync_q[1];

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .winOneHot_o (winOneHot),
    .winIdx_o    (winIdx)
  );

  always_ff @(posedge clk or negedge rstInt) begin
    if (!rstInt) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      dat_q   <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      dat_q   <= dat_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    dat_d   = dat_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = winIdx;
          dat_d   = req_dat[winIdx*DW +: DW];
          rsp_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        // Timeout is checked first so it wins over a simultaneous tx_done.
        if (cnt_q == CW'(TMO - 1)) begin
          rsp_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (spi_tx_done) begin
          rsp_d   = spi_rcvd_dat;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (!spi_tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ownerOneHot = '0;
    for (int i = 0; i < NREQ; i++) ownerOneHot[i] = (owner_q == PW'(i));
  end

  always_comb begin
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    rsp_dat   = '0;
    busy      = (state_q != S_IDLE);
    spi_p_dat = '0;
    spi_tx_en = 1'b0;
    case (state_q)
      S_IDLE: gnt = rstInt ? winOneHot : '0;
      S_LOAD, S_XFER: begin
        spi_p_dat = dat_q;
        spi_tx_en = 1'b1;
      end
      S_DONE: begin
        spi_p_dat = dat_q;
        done      = ownerOneHot;
        err       = err_q;
        rsp_dat   = rsp_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (NREQ=4, DW=8, TMO=20).
module tb_spi_arbiter;

  localparam int TMO_TB = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_dat;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic [7:0]  rsp_dat;
  logic        busy;
  logic [7:0]  spi_p_dat;
  logic        spi_tx_en;
  logic [7:0]  spi_rcvd_dat;
  logic        spi_tx_done;

  int checks = 0;
  int errors = 0;

  spi_arbiter #(.NREQ(4), .DW(8), .TMO(TMO_TB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dat      (req_dat),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .rsp_dat      (rsp_dat),
    .busy         (busy),
    .spi_p_dat    (spi_p_dat),
    .spi_tx_en    (spi_tx_en),
    .spi_rcvd_dat (spi_rcvd_dat),
    .spi_tx_done  (spi_tx_done)
  );

  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer starting and ending in IDLE. nXfer is the XFER cycle in
  // which tx_done is raised; holdExtra is how many GAP cycles it stays high.
  task automatic applyStimulus(input string tag, input logic [3:0] reqV, input logic [3:0] expGnt,
                               input logic [7:0] expTx, input int nXfer, input logic [7:0] rcvd,
                               input logic expTmo, input int holdExtra, input logic [3:0] reqAfter);
    logic [31:0] savedDat;
    savedDat = req_dat;
    req = reqV;
    #1;
    checkOutput({tag, ".gnt"}, {28'd0, gnt}, {28'd0, expGnt});
    checkOutput({tag, ".idleBusy"}, {31'd0, busy}, 32'd0);
    waitCycles(1);
    req     = reqAfter;
    req_dat = ~savedDat;
    #1;
    checkOutput({tag, ".load"}, {gnt, spi_tx_en, busy, spi_p_dat}, {4'b0000, 1'b1, 1'b1, expTx});
    waitCycles(1);
    if (expTmo) begin
      spi_rcvd_dat = 8'hEE;
      for (int k = 1; k <= TMO_TB; k++) begin
        checkOutput({tag, ".xfer"}, {done, spi_tx_en, spi_p_dat}, {4'b0000, 1'b1, expTx});
        waitCycles(1);
      end
    end else begin
      for (int k = 1; k < nXfer; k++) begin
        checkOutput({tag, ".xfer"}, {done, spi_tx_en, spi_p_dat}, {4'b0000, 1'b1, expTx});
        waitCycles(1);
      end
      checkOutput({tag, ".xferLast"}, {done, spi_tx_en}, {4'b0000, 1'b1});
      spi_tx_done  = 1'b1;
      spi_rcvd_dat = rcvd;
      waitCycles(1);
    end
    spi_rcvd_dat = 8'h5A;
    #1;
    checkOutput({tag, ".done"}, {28'd0, done}, {28'd0, expGnt});
    checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, expTmo});
    checkOutput({tag, ".rsp"}, {24'd0, rsp_dat}, {24'd0, (expTmo ? 8'h00 : rcvd)});
    checkOutput({tag, ".doneBus"}, {spi_tx_en, busy, spi_p_dat}, {1'b0, 1'b1, expTx});
    if (holdExtra == 0) spi_tx_done = 1'b0;
    waitCycles(1);
    for (int g = 1; g <= ((holdExtra > 0) ? holdExtra : 1); g++) begin
      checkOutput({tag, ".gap"}, {busy, done, err, spi_tx_en}, {1'b1, 4'b0000, 1'b0, 1'b0});
      if (g == holdExtra) spi_tx_done = 1'b0;
      waitCycles(1);
    end
    req_dat = savedDat;
    checkOutput({tag, ".backIdle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    req          = '0;
    req_dat      = {8'hD4, 8'hC3, 8'h69, 8'hA1};
    spi_rcvd_dat = '0;
    spi_tx_done  = 1'b0;
    #2 rst = 1'b0;
    req = 4'b0001;
    waitCycles(2);
    checkOutput("rst.outs", {5'd0, gnt, done, err, busy, spi_tx_en, spi_p_dat, rsp_dat}, 32'd0);

    req = '0;
    rst = 1'b1;
    waitCycles(3);
    checkOutput("idle.outs", {5'd0, gnt, done, err, busy, spi_tx_en, spi_p_dat, rsp_dat}, 32'd0);

    $display("[TB] fairness");
    applyStimulus("fair0", 4'b1111, 4'b0001, 8'hA1, 1, 8'h11, 1'b0, 0, 4'b1111);
    applyStimulus("fair1", 4'b1111, 4'b0010, 8'h69, 2, 8'h22, 1'b0, 0, 4'b1111);
    applyStimulus("fair2", 4'b1111, 4'b0100, 8'hC3, 3, 8'h33, 1'b0, 0, 4'b1111);
    applyStimulus("fair3", 4'b1111, 4'b1000, 8'hD4, 4, 8'h44, 1'b0, 0, 4'b1111);
    applyStimulus("fair4", 4'b1111, 4'b0001, 8'hA1, 1, 8'h55, 1'b0, 0, 4'b0000);

    $display("[TB] single request");
    applyStimulus("single", 4'b0010, 4'b0010, 8'h69, 10, 8'h96, 1'b0, 0, 4'b0000);

    $display("[TB] wrap");
    applyStimulus("prep", 4'b0100, 4'b0100, 8'hC3, 2, 8'h77, 1'b0, 0, 4'b0000);
    applyStimulus("wrap0", 4'b0101, 4'b0001, 8'hA1, 2, 8'h81, 1'b0, 0, 4'b0101);
    applyStimulus("wrap1", 4'b0101, 4'b0100, 8'hC3, 2, 8'h82, 1'b0, 0, 4'b0000);

    $display("[TB] timeout then level done");
    applyStimulus("tmo", 4'b0011, 4'b0001, 8'hA1, 0, 8'h00, 1'b1, 0, 4'b0010);
    applyStimulus("level", 4'b0010, 4'b0010, 8'h69, 3, 8'hC7, 1'b0, 3, 4'b0000);

    $display("[TB] reset mid-transfer");
    req = 4'b0001;
    #1;
    checkOutput("rstx.gnt", {28'd0, gnt}, 32'h1);
    waitCycles(1);
    req = '0;
    waitCycles(3);
    checkOutput("rstx.txenBefore", {31'd0, spi_tx_en}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rstx.txenNow", {30'd0, spi_tx_en, busy}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      waitCycles(1);
      checkOutput("rstx.held", {25'd0, done, err, spi_tx_en, busy}, 32'd0);
    end
    rst = 1'b1;
    req = 4'b1111;
    #1;
    checkOutput("rstx.sync0", {28'd0, gnt}, 32'd0);
    waitCycles(1);
    checkOutput("rstx.sync1", {28'd0, gnt}, 32'd0);
    waitCycles(1);
    applyStimulus("postrst", 4'b1111, 4'b0001, 8'hA1, 1, 8'h3C, 1'b0, 0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter DW, default 8, meaning the SPI word width.
REQ-003 The block SHALL have parameter TMO, default 255, meaning the maximum XFER cycles before abort.
REQ-004 The block SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req  in  NREQ  per-requester level request; held until granted.
REQ-007 The block SHALL have port req_dat  in  NREQ*DW  per-requester TX word; requester i uses slice [i*DW +: DW].
REQ-008 The block SHALL have port gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
REQ-009 The block SHALL have port done  out  NREQ  one-hot, one-cycle completion pulse.
REQ-010 The block SHALL have port err  out  1  one-cycle pulse, coincident with done, on timeout abort.
REQ-011 The block SHALL have port rsp_dat  out  DW  received word; valid only in the done cycle.
REQ-012 The block SHALL have port busy  out  1  high in every state other than IDLE.
REQ-013 The block SHALL have port spi_p_dat  out  DW  word to the SPI top.
REQ-014 The block SHALL have port spi_tx_en  out  1  transfer enable to the SPI top; level.
REQ-015 The block SHALL have port spi_rcvd_dat  in  DW  received word from the SPI top.
REQ-016 The block SHALL have port spi_tx_done  in  1  transfer-complete from the SPI top; pulse or level.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, XFER, DONE, GAP.
REQ-018 In IDLE with any req bit high, the FSM SHALL select the winner round-robin starting at pointer ptr.
- Latch owner and req_dat slice.
- Pulse gnt[owner].
- Go to LOAD.
REQ-019 In IDLE with req all zero, the FSM SHALL stay in IDLE with every output at its reset value.
REQ-020 In LOAD, spi_p_dat SHALL present the latched word and spi_tx_en SHALL rise; next state is XFER.
REQ-021 spi_p_dat SHALL stay stable from LOAD through DONE, independent of later req_dat changes.
REQ-022 In XFER, spi_tx_en SHALL hold high until spi_tx_done is sampled high or the cycle counter reaches TMO.
REQ-023 On spi_tx_done, the block SHALL capture spi_rcvd_dat into rsp_dat, drop spi_tx_en and go to DONE.
REQ-024 On timeout, the block SHALL drop spi_tx_en, set rsp_dat to 0, pulse err in DONE and go to DONE.
REQ-025 Timeout SHALL take precedence if spi_tx_done and timeout occur in the same cycle.
REQ-026 In DONE, done[owner] SHALL pulse for one cycle, ptr SHALL become (owner+1) mod NREQ, and next state is GAP.
REQ-027 In GAP, the FSM SHALL wait until spi_tx_done is low, then go to IDLE, so a level-style done is not double-counted.
REQ-028 Minimum latency from grant to done SHALL be 3 cycles: gnt at t, tx_en at t+1, done at t+2+N, where N is the number of XFER cycles.
REQ-029 A requester deasserting req after grant SHALL NOT cancel the transfer.
REQ-030 A req change during a transfer SHALL only affect the next arbitration.
REQ-031 ptr wrap-around SHALL be modulo NREQ; the search SHALL wrap past NREQ-1 to 0.
REQ-032 The XFER counter SHALL be ceil(log2(TMO+1)) bits wide, clear on entry to XFER, and not wrap.

Reset
REQ-033 While rst is low, all state SHALL clear asynchronously.
- State = IDLE; ptr = 0; owner = 0; counter = 0.
- gnt = 0, done = 0, err = 0, busy = 0.
- rsp_dat = 0, spi_p_dat = 0, spi_tx_en = 0.
REQ-034 Reset asserted mid-transfer SHALL drop spi_tx_en immediately, with no done or err pulse for the aborted owner.
REQ-035 Release of rst SHALL be synchronised to clk inside the block with a 2-flop release synchroniser.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, default DW, and the default TMO constant.
REQ-037 The round-robin picker SHALL be a combinational sub-module, rr_pick: inputs req and ptr, outputs a one-hot winner and its index.

Verification
REQ-038 Single request: req=4'b0010, req_dat[15:8]=8'h69, spi_tx_done after 10 cycles with spi_rcvd_dat=8'h96 -> expected response:
- gnt=4'b0010 for one cycle.
- spi_p_dat=8'h69.
- done=4'b0010 with rsp_dat=8'h96.
- err=0.
REQ-039 Fairness: req=4'b1111 held for four transfers -> grants in order 0001, 0010, 0100, 1000, then 0001.
REQ-040 Wrap: ptr=3 and req=4'b0101 -> grant 0001, then 0100.
REQ-041 Timeout: TMO=20, spi_tx_done never asserted -> expected response:
- spi_tx_en drops after 20 XFER cycles.
- done and err pulse together with rsp_dat=0.
- The next requester is served.
REQ-042 Level done: spi_tx_done held high 5 cycles -> exactly one done pulse; FSM waits in GAP until it falls.
REQ-043 Reset mid-XFER: rst low 3 cycles during XFER -> spi_tx_en=0 at once, no done pulse, ptr=0 after release.
